// File: rtl/adc_audio_conditioner.sv
// adc_audio_conditioner
// Turns raw unipolar 12-bit ADC codes into signed 16-bit PCM words.
// The datapath removes the DC bias, box-car averages 2^AVG_LOG2 samples
// per output word and raises a sticky flag on ADC rail codes.
// It is a three-stage pipeline: capture, centre, accumulate.
// Optional feature macro: ADC_DC_TRACK_EN. When it is defined, a
// first-order tracker replaces the fixed mid-scale bias of 2048.
module adc_audio_conditioner #(
    parameter int AVG_LOG2 = 3,   // log2 of samples per output word (0..6)
    parameter int DC_SHIFT = 10   // log2 of DC-tracker time constant
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic [11:0]        adc_data,
    input  logic               mute,
    input  logic               clear_clip,
    output logic signed [15:0] audio_sample,
    output logic               audio_valid,
    output logic               clip
);

    localparam int ACC_W = 13 + AVG_LOG2;
    // Keep one counter bit even in pass-through mode. CNT_MAX is 0 there,
    // so every sample closes a group.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

    // Pipeline registers
    logic [11:0]              r_x;
    logic                     r_v1;
    logic signed [12:0]       r_s;
    logic                     r_v2;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;

    // Combinational datapath
    logic [11:0]              w_dc;
    logic signed [12:0]       w_s;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [12:0]       w_avg;
    logic                     w_rail;

    // Centre the captured code against the current bias. The result is
    // 13-bit signed and lies in -4095..4095.
    assign w_s = $signed({1'b0, r_x}) - $signed({1'b0, w_dc});

    // The group sum of 2^AVG_LOG2 values in -4095..4095 always fits in
    // ACC_W bits, so the accumulator needs no overflow guard.
    assign w_sum     = r_acc + ACC_W'(r_s);
    assign w_shifted = w_sum >>> AVG_LOG2;
    assign w_avg     = w_shifted[12:0];

    assign w_rail = (adc_data == 12'd0) || (adc_data == 12'hFFF);

`ifdef ADC_DC_TRACK_EN
    localparam int DC_W = 12 + DC_SHIFT;

    logic [DC_W-1:0]      r_dc_acc;
    logic signed [DC_W:0] w_dc_sum;

    // The leaky integrator adds the freshly centred sample, which uses the
    // old bias. dc_acc settles at (mean << DC_SHIFT), so it cannot overflow.
    assign w_dc_sum = $signed({1'b0, r_dc_acc}) + (DC_W + 1)'(w_s);
    assign w_dc     = r_dc_acc[DC_W-1:DC_SHIFT];

    // DC tracker: advance once per centred sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dc_acc <= DC_W'(2048) << DC_SHIFT;
        end else if (r_v1) begin
            r_dc_acc <= w_dc_sum[DC_W-1:0];
        end
    end
`else
    assign w_dc = 12'd2048;
`endif

    // S1: capture the raw code and its strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x  <= '0;
            r_v1 <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments. All stages then
            // sample pre-edge values, which lets the pipeline advance
            // in lock-step.
            r_v1 <= sample_valid;
            if (sample_valid) begin
                r_x <= adc_data;
            end
        end
    end

    // S2: remove the DC bias
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s  <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s <= w_s;
            end
        end
    end

    // S3: accumulate a group and emit its floor average scaled to 16 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            audio_sample <= '0;
            audio_valid  <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            if (r_v2) begin
                if (r_cnt != CNT_MAX) begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    // The output needs no saturation: -4096<<3 is -32768
                    // and 4095<<3 is 32760.
                    audio_sample <= mute ? 16'sd0 : $signed({w_avg, 3'b000});
                    audio_valid  <= 1'b1;
                    r_acc        <= '0;
                    r_cnt        <= '0;
                end
            end
        end
    end

    // Sticky rail-clip flag; a new rail code wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip <= 1'b0;
        end else if (sample_valid && w_rail) begin
            clip <= 1'b1;
        end else if (clear_clip) begin
            clip <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_audio_conditioner.sv
// Self-checking bench for adc_audio_conditioner.
// With the default build, a scoreboard model predicts every PCM word and
// when it appears. With ADC_DC_TRACK_EN defined, the bench runs the
// DC-tracker convergence scenario instead.
module tb_adc_audio_conditioner;

`ifdef ADC_DC_TRACK_EN
    localparam int AVG = 0;
    localparam int SH  = 4;
`else
    localparam int AVG = 3;
    localparam int SH  = 10;
`endif
    localparam int GROUP = 1 << AVG;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic [11:0]        adc_data = '0;
    logic               mute = 1'b0;
    logic               clear_clip = 1'b0;
    logic signed [15:0] audio_sample;
    logic               audio_valid;
    logic               clip;

    adc_audio_conditioner #(.AVG_LOG2(AVG), .DC_SHIFT(SH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .adc_data     (adc_data),
        .mute         (mute),
        .clear_clip   (clear_clip),
        .audio_sample (audio_sample),
        .audio_valid  (audio_valid),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int word;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   obs_q[$];
    int   m_sum = 0;
    int   m_cnt = 0;

    // Drive one strobe on a falling edge and update the reference model.
    // The strobe stays high until a later call or idle() changes it.
    task automatic strobe(input int code);
        exp_t e;
        @(negedge clk);
        sample_valid = 1'b1;
        adc_data     = 12'(code);
        m_sum += code - 2048;
        m_cnt++;
        if (m_cnt == GROUP) begin
            e.word = mute ? 0 : ((m_sum >>> AVG) * 8);
            e.due  = cyc + 3;
            sb_q.push_back(e);
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            clear_clip   = 1'b0;
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (audio_valid) begin
`ifdef ADC_DC_TRACK_EN
            obs_q.push_back(int'(audio_sample));
`else
            if (sb_q.size() == 0) begin
                check_eq("unexpected_word", int'(audio_sample), 99999);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("word", int'(audio_sample), e.word);
                check_eq("latency", cyc, e.due);
            end
`endif
        end
    end

    initial begin
        idle(2);
        check_eq("rst_audio_sample", int'(audio_sample), 0);
        check_eq("rst_audio_valid", int'(audio_valid), 0);
        check_eq("rst_clip", int'(clip), 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

`ifdef ADC_DC_TRACK_EN
        for (int i = 0; i < 200; i++) strobe(3000);
        idle(6);
        sb_q.delete();
        check_eq("trk_count", obs_q.size(), 200);
        if (obs_q.size() == 200) begin
            int viol = 0;
            int a_prev;
            int a_cur;
            int a_last;
            check_eq("trk_first", obs_q[0], 7616);
            for (int i = 1; i < 200; i++) begin
                a_prev = (obs_q[i-1] < 0) ? -obs_q[i-1] : obs_q[i-1];
                a_cur  = (obs_q[i]   < 0) ? -obs_q[i]   : obs_q[i];
                if (a_cur > a_prev) viol++;
            end
            check_eq("trk_monotonic_violations", viol, 0);
            a_last = (obs_q[199] < 0) ? -obs_q[199] : obs_q[199];
            check_eq("trk_converged", int'(a_last <= 8), 1);
        end
        check_eq("trk_clip", int'(clip), 0);
`else
        // Mid-scale input gives silence and no clip.
        for (int i = 0; i < GROUP; i++) strobe(2048);
        idle(5);
        check_eq("midscale_clip", int'(clip), 0);

        // Positive rail, back to back; clip appears one cycle after strobe 1.
        for (int i = 0; i < GROUP; i++) begin
            strobe(4095);
            if (i == 1) check_eq("clip_set_latency", int'(clip), 1);
        end
        idle(5);

        // A rail capture and a clear on the same edge: the set wins.
        strobe(4095);
        clear_clip = 1'b1;
        idle(1);
        check_eq("clip_set_beats_clear", int'(clip), 1);
        for (int i = 1; i < GROUP; i++) strobe(2048);
        idle(5);
        @(negedge clk);
        clear_clip = 1'b1;
        idle(1);
        check_eq("clip_cleared", int'(clip), 0);

        // Negative rail, then alternating codes that average to zero.
        for (int i = 0; i < GROUP; i++) strobe(0);
        idle(1);
        check_eq("clip_zero_rail", int'(clip), 1);
        for (int i = 0; i < GROUP / 2; i++) begin
            strobe(1000);
            strobe(3000);
        end
        idle(5);

        // Muted group still produces a strobe, with a zero word.
        mute = 1'b1;
        for (int i = 0; i < GROUP; i++) strobe(3000);
        idle(5);
        mute = 1'b0;

        // Reset in mid-group discards the partial sum.
        for (int i = 0; i < 5; i++) strobe(3000);
        idle(1);
        reset_n = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        idle(2);
        check_eq("midrst_audio_valid", int'(audio_valid), 0);
        check_eq("midrst_clip", int'(clip), 0);
        reset_n = 1'b1;
        idle(1);
        for (int i = 0; i < GROUP; i++) strobe(2048);
        idle(5);

        // Random non-rail groups exercise the floor average on mixed signs.
        for (int i = 0; i < 3 * GROUP; i++) strobe(int'($urandom_range(1, 4094)));
        idle(2);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
